switch_inport_loader: RTL and testbench

Upstream front-end for the memory-mapped input ports. Synchronizes and debounces the board switches and the load push-button. On each debounced press it captures the switch value, extends it to WIDTH and pulses exactly one of the two in-port enables. Its outputs drive the memory block's Extended_Switch_Data, Inport0En and Inport1En inputs directly.

---
 rtl/switch_inport_loader.sv | 145 ++++++++++++++
 tb/tb_switch_inport_loader.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/switch_inport_loader.sv
// ============================================================================
// Module      : switch_inport_loader
// Description : Synchronizes/debounces board switches and load button; pulses
//               one in-port enable per debounced press with extended data.
//               Optional macro SWITCH_SIGN_EXT_EN selects sign extension.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module switch_inport_loader #(
  parameter int WIDTH           = 32,
  parameter int SW_WIDTH        = 10,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_WIDTH       = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SW_WIDTH-1:0] switches,
  input  logic                btn_n,
  output logic [WIDTH-1:0]    Extended_Switch_Data,
  output logic                Inport0En,
  output logic                Inport1En,
  output logic                busy
);

  typedef enum logic [1:0] {
    S_IDLE         = 2'd0,
    S_PRESS_WAIT   = 2'd1,
    S_HELD         = 2'd2,
    S_RELEASE_WAIT = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] c_cnt_last = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] c_cnt_one  = CNT_WIDTH'(1);

  logic [SW_WIDTH-1:0] sw_meta_q;
  logic [SW_WIDTH-1:0] sw_sync_q;
  logic                btn_meta_q;
  logic                btn_sync_q;

  state_t              state_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0]    data_q;
  logic                en0_q;
  logic                en1_q;
  logic                busy_q;

  logic                pressed;
  logic [WIDTH-1:0]    ext_data;

  // Button synchronizer resets to the released level so reset never looks like a press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      btn_meta_q <= 1'b1;
      btn_sync_q <= 1'b1;
    end else begin
      sw_meta_q  <= switches;
      sw_sync_q  <= sw_meta_q;
      btn_meta_q <= btn_n;
      btn_sync_q <= btn_meta_q;
    end
  end

  assign pressed = ~btn_sync_q;
  assign cnt_d   = cnt_q + c_cnt_one;

`ifdef SWITCH_SIGN_EXT_EN
  assign ext_data = {{(WIDTH-SW_WIDTH+1){sw_sync_q[SW_WIDTH-2]}}, sw_sync_q[SW_WIDTH-2:0]};
`else
  assign ext_data = {{(WIDTH-SW_WIDTH+1){1'b0}}, sw_sync_q[SW_WIDTH-2:0]};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      en0_q   <= 1'b0;
      en1_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      // Enables only ever rise on the capture edge, giving single-cycle pulses.
      en0_q <= 1'b0;
      en1_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pressed) begin
            state_q <= S_PRESS_WAIT;
            cnt_q   <= c_cnt_one;
            busy_q  <= 1'b1;
          end
        end
        S_PRESS_WAIT: begin
          if (!pressed) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (cnt_q == c_cnt_last) begin
            state_q <= S_HELD;
            cnt_q   <= '0;
            data_q  <= ext_data;
            en0_q   <= ~sw_sync_q[SW_WIDTH-1];
            en1_q   <= sw_sync_q[SW_WIDTH-1];
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_HELD: begin
          if (!pressed) begin
            state_q <= S_RELEASE_WAIT;
            cnt_q   <= c_cnt_one;
          end
        end
        S_RELEASE_WAIT: begin
          if (pressed) begin
            state_q <= S_HELD;
            cnt_q   <= '0;
          end else if (cnt_q == c_cnt_last) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Extended_Switch_Data = data_q;
  assign Inport0En            = en0_q;
  assign Inport1En            = en1_q;
  assign busy                 = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_switch_inport_loader.sv
// ============================================================================
// Module      : tb_switch_inport_loader
// Description : Self-checking bench for switch_inport_loader (DEBOUNCE_CYCLES=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_switch_inport_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  switches = '0;
  logic        btn_n = 1'b1;
  logic [31:0] data;
  logic        en0;
  logic        en1;
  logic        busy;

  always #5 clk = ~clk;

  switch_inport_loader #(
    .WIDTH(32), .SW_WIDTH(10), .DEBOUNCE_CYCLES(4), .CNT_WIDTH(20)
  ) dut (
    .clk(clk), .rst(rst), .switches(switches), .btn_n(btn_n),
    .Extended_Switch_Data(data), .Inport0En(en0), .Inport1En(en1), .busy(busy)
  );

  typedef struct packed {
    logic        port;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic [9:0] sw;
    int         hold;
    int         pulses;
    int         rel_ticks;
  } vec_t;

  exp_t        sb_q[$];
  vec_t        vecs[6];
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_pulses = 0;
  bit          pulse_seen = 1'b0;
  logic [31:0] last_data = '0;

  function automatic logic [31:0] model_ext(input logic [9:0] sw);
`ifdef SWITCH_SIGN_EXT_EN
    return {{23{sw[8]}}, sw[8:0]};
`else
    return {23'd0, sw[8:0]};
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic expect_pulse(input logic [9:0] sw);
    exp_t e;
    e.port = sw[9];
    e.data = model_ext(sw);
    sb_q.push_back(e);
  endtask

  // One clock; outputs are sampled on the falling edge and scored here.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    pulse_seen = 1'b0;
    check("mutex", {31'd0, en0 & en1}, 32'd0);
    if (en0 || en1) begin
      pulse_seen = 1'b1;
      n_pulses++;
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_pulse: actual en0=%0b en1=%0b data=%h required no pulse", en0, en1, data);
      end else begin
        e = sb_q.pop_front();
        check("pulse_port", {31'd0, en1}, {31'd0, e.port});
        check("pulse_data", data, e.data);
        last_data = e.data;
      end
    end else begin
      check("data_hold", data, last_data);
    end
  endtask

  task automatic wait_pulse(input string name, input int exp_lat);
    int lat;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (pulse_seen) begin
        lat = i;
        break;
      end
    end
    check(name, lat, exp_lat);
  endtask

  task automatic release_idle(input int exp_ticks);
    int t;
    t = 0;
    btn_n = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (!busy) begin
        t = i;
        break;
      end
    end
    check("busy_release_ticks", t, exp_ticks);
    repeat (4) tick();
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("pending_pulses", sb_q.size(), 32'd0);
  endtask

  initial begin
    int p0;

    vecs[0] = '{10'h0A5, 12, 1, 6};
    vecs[1] = '{10'h3FF, 12, 1, 6};
    vecs[2] = '{10'h200, 12, 1, 6};
    vecs[3] = '{10'h1FF, 12, 1, 6};
    vecs[4] = '{10'h0FF, 4,  1, 6};
    vecs[5] = '{10'h055, 3,  0, 3};

    // Reset held with the button down; outputs must stay clear.
    #2 rst = 1'b0;
    btn_n    = 1'b0;
    switches = 10'h012;
    last_data = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_data", data, 32'd0);
      check("rst_en0", {31'd0, en0}, 32'd0);
      check("rst_en1", {31'd0, en1}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
    end
    expect_pulse(10'h012);
    rst = 1'b1;
    wait_pulse("latency_after_reset", 6);
    release_idle(6);

    for (int v = 0; v < 6; v++) begin
      switches = vecs[v].sw;
      repeat (3) tick();
      p0 = n_pulses;
      if (vecs[v].pulses != 0) expect_pulse(vecs[v].sw);
      btn_n = 1'b0;
      repeat (vecs[v].hold) tick();
      release_idle(vecs[v].rel_ticks);
      check("vec_pulse_count", n_pulses - p0, vecs[v].pulses);
    end

    // Bounce never reaches the debounce threshold.
    p0 = n_pulses;
    btn_n = 1'b0; repeat (2) tick();
    btn_n = 1'b1; tick();
    btn_n = 1'b0; repeat (3) tick();
    btn_n = 1'b1; repeat (10) tick();
    check("bounce_pulses", n_pulses - p0, 0);
    check("bounce_busy", {31'd0, busy}, 32'd0);
    check("bounce_data", data, last_data);

    // Long hold with a release glitch and switch change mid-hold.
    switches = 10'h0A5;
    repeat (3) tick();
    p0 = n_pulses;
    expect_pulse(10'h0A5);
    btn_n = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (i == 30) switches = 10'h155;
      if (i == 50) btn_n = 1'b1;
      if (i == 52) btn_n = 1'b0;
      tick();
    end
    release_idle(6);
    check("glitch_pulses", n_pulses - p0, 1);
    check("glitch_data", data, model_ext(10'h0A5));

    // Asynchronous reset right after a pulse, button kept held.
    switches = 10'h0A5;
    repeat (3) tick();
    expect_pulse(10'h0A5);
    btn_n = 1'b0;
    wait_pulse("latency_before_abort", 6);
    rst = 1'b0;
    #1;
    check("async_rst_data", data, 32'd0);
    check("async_rst_en0", {31'd0, en0}, 32'd0);
    check("async_rst_en1", {31'd0, en1}, 32'd0);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    sb_q.delete();
    last_data = '0;
    switches = 10'h3C3;
    repeat (2) tick();
    expect_pulse(10'h3C3);
    rst = 1'b1;
    wait_pulse("latency_after_abort", 6);
    release_idle(6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
